seg_scroll_ctrl: RTL and testbench

SEG_SCROLL_CTRL -- requirements
Module: seg_scroll_ctrl

---
 rtl/seg_scroll_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_seg_scroll_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scroll_ctrl.sv
// seg_scroll_ctrl: scrolling message controller for a six-digit 7-segment display.
//
// Loads up to eight 4-bit codes over a valid/ready handshake and scrolls them
// across six digits (hex5..hex0). The scrolled sequence is the message followed
// by six blanks, so the text slides fully off the display before it repeats.
//
// Parameters:
//   TICK_DIV     clock cycles per scroll step (2..2^26)
// Optional build macro:
//   SEG_SCROLL_DIR_EN  adds input dir; dir=1 scrolls backwards (sampled at each step)
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   wr_valid/wr_code  message load handshake; wr_ready high in IDLE while buffer not full
//   start/stop/clear  control pulses (priority clear > stop > start > write)
//   hold              freezes the scroll timer while high
//   digit_code        six 4-bit codes, [23:20]=hex5 .. [3:0]=hex0 (registered)
//   digit_blank       per-digit blank flags, [5]=hex5 .. [0]=hex0 (registered)
//   busy              high while scrolling
//   step              one-cycle pulse on each scroll advance
module seg_scroll_ctrl #(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic        clk,
   input  logic        reset_n,
`ifdef SEG_SCROLL_DIR_EN
   input  logic        dir,
`endif
   input  logic        wr_valid,
   input  logic [3:0]  wr_code,
   output logic        wr_ready,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic        hold,
   output logic [23:0] digit_code,
   output logic [5:0]  digit_blank,
   output logic        busy,
   output logic        step
);

   localparam int unsigned DEPTH   = 8;
   localparam int unsigned DIGITS  = 6;
   localparam int unsigned TIMER_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TICK_DIV - 1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_SCROLL = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           count_q, count_d;
   logic [3:0]           offset_q, offset_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [3:0]           buf_q [DEPTH];
   logic                 wr_en;
   logic                 step_d;
   logic [3:0]           offset_adv;
   logic [4:0]           seq_len;
   logic [23:0]          digit_code_d;
   logic [5:0]           digit_blank_d;

   // Virtual sequence length: message plus six trailing blanks.
   assign seq_len = 5'(count_q) + 5'd6;

   // Next offset when a step fires; wraps modulo the sequence length.
   always_comb begin
      offset_adv = offset_q + 4'd1;
      if ((5'(offset_q) + 5'd1) == seq_len) begin
         offset_adv = 4'd0;
      end
`ifdef SEG_SCROLL_DIR_EN
      if (dir) begin
         if (offset_q == 4'd0) begin
            offset_adv = 4'(seq_len - 5'd1);
         end else begin
            offset_adv = offset_q - 4'd1;
         end
      end
`endif
   end

   // State register and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         count_q  <= 4'd0;
         offset_q <= 4'd0;
         timer_q  <= '0;
         step     <= 1'b0;
         busy     <= 1'b0;
         wr_ready <= 1'b1;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         offset_q <= offset_d;
         timer_q  <= timer_d;
         step     <= step_d;
         busy     <= (state_d == ST_SCROLL);
         // Registered from next state so it always matches IDLE && count<8.
         wr_ready <= (state_d == ST_IDLE) && (count_d < 4'(DEPTH));
      end
   end

   // Next-state, timer and handshake decode; clear > stop > start > write.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      offset_d = offset_q;
      timer_d  = timer_q;
      step_d   = 1'b0;
      wr_en    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (clear) begin
               count_d  = 4'd0;
               offset_d = 4'd0;
            end else if (stop) begin
               offset_d = 4'd0;
            end else if (start && (count_q != 4'd0)) begin
               state_d  = ST_SCROLL;
               offset_d = 4'd0;
               timer_d  = '0;
            end else if (wr_valid && wr_ready) begin
               wr_en   = 1'b1;
               count_d = count_q + 4'd1;
            end
         end
         ST_SCROLL: begin
            if (clear) begin
               state_d  = ST_IDLE;
               count_d  = 4'd0;
               offset_d = 4'd0;
               timer_d  = '0;
            end else if (stop) begin
               state_d  = ST_IDLE;
               offset_d = 4'd0;
               timer_d  = '0;
            end else if (!hold) begin
               if (timer_q == TIMER_LAST) begin
                  timer_d  = '0;
                  offset_d = offset_adv;
                  step_d   = 1'b1;
               end else begin
                  timer_d = timer_q + TIMER_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Message buffer; reset discards contents.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            buf_q[k] <= 4'd0;
         end
      end else if (wr_en) begin
         buf_q[count_q[2:0]] <= wr_code;
      end
   end

   // Window decode: digit i shows sequence index (offset+i) mod L.
   // offset < L and L >= 6, so one conditional subtract is enough.
   always_comb begin
      logic [4:0] s;
      logic [4:0] j;
      digit_code_d  = 24'd0;
      digit_blank_d = 6'b111111;
      s = 5'd0;
      j = 5'd0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         s = 5'(offset_q) + 5'(i);
         j = (s >= seq_len) ? (s - seq_len) : s;
         if (j < 5'(count_q)) begin
            digit_code_d[(5 - i) * 4 +: 4] = buf_q[j[2:0]];
            digit_blank_d[5 - i]           = 1'b0;
         end
      end
   end

   // Display registers lag buffer/offset by one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         digit_code  <= 24'd0;
         digit_blank <= 6'b111111;
      end else begin
         digit_code  <= digit_code_d;
         digit_blank <= digit_blank_d;
      end
   end

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
module tb_seg_scroll_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        dir = 1'b0;
   logic        wr_valid = 1'b0;
   logic [3:0]  wr_code = 4'd0;
   logic        wr_ready;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        clear = 1'b0;
   logic        hold = 1'b0;
   logic [23:0] digit_code;
   logic [5:0]  digit_blank;
   logic        busy;
   logic        step;

   int errors = 0;
   int checks = 0;

   seg_scroll_ctrl #(.TICK_DIV(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
`ifdef SEG_SCROLL_DIR_EN
      .dir         (dir),
`endif
      .wr_valid    (wr_valid),
      .wr_code     (wr_code),
      .wr_ready    (wr_ready),
      .start       (start),
      .stop        (stop),
      .clear       (clear),
      .hold        (hold),
      .digit_code  (digit_code),
      .digit_blank (digit_blank),
      .busy        (busy),
      .step        (step)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled on the falling edge.
   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      tick(2);
      checks++;
      if (digit_blank !== 6'b111111) begin
         errors++;
         $display("FAIL reset_blank: got %b want 111111", digit_blank);
      end
      checks++;
      if (digit_code !== 24'h000000) begin
         errors++;
         $display("FAIL reset_code: got %h want 000000", digit_code);
      end
      checks++;
      if (wr_ready !== 1'b1 || busy !== 1'b0 || step !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got ready=%b busy=%b step=%b want 1 0 0", wr_ready, busy, step);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_load;
      wr_valid = 1'b1;
      wr_code = 4'd1;
      tick();
      wr_code = 4'd2;
      tick();
      wr_code = 4'd3;
      tick();
      wr_valid = 1'b0;
      // Display still reflects the two-entry buffer.
      checks++;
      if (digit_code !== 24'h120000 || digit_blank !== 6'b001111) begin
         errors++;
         $display("FAIL load_latency: got %h/%b want 120000/001111", digit_code, digit_blank);
      end
      tick();
      checks++;
      if (digit_code !== 24'h123000 || digit_blank !== 6'b000111) begin
         errors++;
         $display("FAIL load_static: got %h/%b want 123000/000111", digit_code, digit_blank);
      end
      checks++;
      if (busy !== 1'b0 || step !== 1'b0) begin
         errors++;
         $display("FAIL load_idle: got busy=%b step=%b want 0 0", busy, step);
      end
   endtask

   task automatic test_scroll;
      int steps;
      steps = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL scroll_enter: got busy=%b ready=%b want 1 0", busy, wr_ready);
      end
      for (int k = 1; k <= 41; k++) begin
         tick();
         if (step === 1'b1) steps++;
         checks++;
         if (step !== ((k % 4) == 0)) begin
            errors++;
            $display("FAIL scroll_step_k%0d: got %b want %b", k, step, (k % 4) == 0);
         end
         if (k == 5) begin
            checks++;
            if (digit_code[23:20] !== 4'd2 || digit_code !== 24'h230000 || digit_blank !== 6'b001111) begin
               errors++;
               $display("FAIL scroll_first: got %h/%b want 230000/001111", digit_code, digit_blank);
            end
         end
         if (k == 33) begin
            checks++;
            if (digit_code !== 24'h012300 || digit_blank !== 6'b100011) begin
               errors++;
               $display("FAIL scroll_off8: got %h/%b want 012300/100011", digit_code, digit_blank);
            end
         end
         if (k == 37) begin
            checks++;
            if (digit_code !== 24'h123000 || digit_blank !== 6'b000111) begin
               errors++;
               $display("FAIL scroll_wrap: got %h/%b want 123000/000111", digit_code, digit_blank);
            end
         end
         if (k == 41) begin
            checks++;
            if (digit_code !== 24'h230000) begin
               errors++;
               $display("FAIL scroll_second_lap: got %h want 230000", digit_code);
            end
         end
      end
      checks++;
      if (steps != 10) begin
         errors++;
         $display("FAIL scroll_step_count: got %0d want 10", steps);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if (busy !== 1'b0 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL stop_ctrl: got busy=%b ready=%b want 0 1", busy, wr_ready);
      end
      tick();
      checks++;
      if (digit_code !== 24'h123000 || digit_blank !== 6'b000111) begin
         errors++;
         $display("FAIL stop_window: got %h/%b want 123000/000111", digit_code, digit_blank);
      end
   endtask

   task automatic test_priority;
      start = 1'b1;
      clear = 1'b1;
      tick();
      start = 1'b0;
      clear = 1'b0;
      checks++;
      if (busy !== 1'b0 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL prio_ctrl: got busy=%b ready=%b want 0 1", busy, wr_ready);
      end
      tick();
      checks++;
      if (digit_blank !== 6'b111111 || digit_code !== 24'h000000) begin
         errors++;
         $display("FAIL prio_cleared: got %h/%b want 000000/111111", digit_code, digit_blank);
      end
   endtask

   task automatic test_hold;
      wr_valid = 1'b1;
      wr_code = 4'd7;
      tick();
      wr_code = 4'd8;
      tick();
      wr_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(2);
      hold = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (step !== 1'b0 || digit_code !== 24'h780000) begin
            errors++;
            $display("FAIL hold_k%0d: got step=%b code=%h want 0 780000", k, step, digit_code);
         end
      end
      hold = 1'b0;
      tick();
      checks++;
      if (step !== 1'b0) begin
         errors++;
         $display("FAIL hold_resume_early: got step=%b want 0", step);
      end
      tick();
      checks++;
      if (step !== 1'b1) begin
         errors++;
         $display("FAIL hold_resume_step: got step=%b want 1", step);
      end
      tick();
      checks++;
      if (digit_code !== 24'h800000 || digit_blank !== 6'b011111) begin
         errors++;
         $display("FAIL hold_resume_window: got %h/%b want 800000/011111", digit_code, digit_blank);
      end
   endtask

   task automatic test_reset_mid;
      tick(2);
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || step !== 1'b0 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_ctrl: got busy=%b step=%b ready=%b want 0 0 1", busy, step, wr_ready);
      end
      checks++;
      if (digit_blank !== 6'b111111 || digit_code !== 24'h000000) begin
         errors++;
         $display("FAIL midreset_digits: got %h/%b want 000000/111111", digit_code, digit_blank);
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL empty_start: got busy=%b want 0", busy);
      end
      tick(5);
      checks++;
      if (busy !== 1'b0 || step !== 1'b0 || digit_blank !== 6'b111111) begin
         errors++;
         $display("FAIL empty_start_later: got busy=%b step=%b blank=%b want 0 0 111111", busy, step, digit_blank);
      end
   endtask

   task automatic test_full;
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (wr_ready !== (k < 8)) begin
            errors++;
            $display("FAIL full_ready_k%0d: got %b want %b", k, wr_ready, k < 8);
         end
         wr_valid = 1'b1;
         wr_code = 4'(k + 1);
         tick();
      end
      wr_valid = 1'b0;
      checks++;
      if (wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_ready_after: got %b want 0", wr_ready);
      end
      tick();
      checks++;
      if (digit_code !== 24'h123456 || digit_blank !== 6'b000000) begin
         errors++;
         $display("FAIL full_window: got %h/%b want 123456/000000", digit_code, digit_blank);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(13);
      // Offset 3 exposes index 8, which must be blank if the 9th code was dropped.
      checks++;
      if (digit_code !== 24'h456780 || digit_blank !== 6'b000001) begin
         errors++;
         $display("FAIL full_no_ninth: got %h/%b want 456780/000001", digit_code, digit_blank);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load();
      test_scroll();
      test_priority();
      test_hold();
      test_reset_mid();
      test_full();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
